humansized_muldiv_seq: RTL and testbench

- Control sequencer directly upstream of the human-sized multiply/divide datapath.
- Accepts an operation request with two W-bit operands and drives the datapath's op[4:0], Di and ci every cycle.
- Observes the datapath's PM output and returns a registered 2W-bit result with a one-cycle done pulse.
- Serves as the control prototype for the midgetv mult/div and uses the same two-cycles-per-bit schedule.

---
 rtl/humansized_muldiv_seq.sv | 190 +++++++++++++++++++
 tb/tb_humansized_muldiv_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/humansized_muldiv_seq.sv
// Control sequencer for the human-sized shift/add multiply/divide datapath.
// Each operand bit takes two cycles; the result is taken from the datapath PM bus.
module humansized_muldiv_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [1:0]     func,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           illegal,
  output logic [W-1:0]   res_hi,
  output logic [W-1:0]   res_lo,
  output logic [4:0]     dp_op,
  output logic [W-1:0]   dp_di,
  output logic           dp_ci,
  input  logic [2*W-1:0] dp_pm
);

  // state  | meaning
  // IDLE   | waiting for start; datapath held cleared by load of 0
  // LOAD   | datapath loads dividend/multiplier into rM, clears rP
  // ITER   | W iterations, each phase 0 then phase 1
  // CAPT   | register PM (or zero for an illegal func) into the result
  // DONE   | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CAPT,
    S_DONE
  } state_t;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] F_MULU = 2'b00;
  localparam logic [1:0] F_MULS = 2'b01;
  localparam logic [1:0] F_DIVU = 2'b10;
  localparam logic [1:0] F_ILL  = 2'b11;

  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_ADDU  = 5'b00000;
  localparam logic [4:0] OP_SRL   = 5'b00010;
  localparam logic [4:0] OP_ADDS  = 5'b01000;
  localparam logic [4:0] OP_SRA   = 5'b00100;
  localparam logic [4:0] OP_SLL   = 5'b00110;
  localparam logic [4:0] OP_TRSUB = 5'b10000;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [1:0]      func_q, func_d;
  logic            illegal_q, illegal_d;
  logic [W-1:0]    res_hi_q, res_hi_d;
  logic [W-1:0]    res_lo_q, res_lo_d;
  logic            last_k;

  assign last_k  = (cnt_q == CW'(W - 1));
  assign illegal = illegal_q;
  assign res_hi  = res_hi_q;
  assign res_lo  = res_lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      illegal_q <= 1'b0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      illegal_q <= illegal_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    illegal_d = illegal_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    busy      = 1'b0;
    done      = 1'b0;
    dp_op     = OP_LOAD;
    dp_di     = '0;
    dp_ci     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          func_d    = func;
          illegal_d = 1'b0;
          // an illegal request still passes through CAPT so done lands two cycles out
          state_d   = (func == F_ILL) ? S_CAPT : S_LOAD;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        dp_di   = a_q;
        cnt_d   = '0;
        phase_d = 1'b0;
        state_d = S_ITER;
      end

      S_ITER: begin
        busy    = 1'b1;
        phase_d = ~phase_q;
        case (func_q)
          F_MULS: begin
            if (!phase_q) begin
              dp_op = OP_ADDS;
              dp_di = last_k ? ~b_q : b_q;
              dp_ci = last_k;
            end else begin
              dp_op = OP_SRA;
            end
          end
          F_DIVU: begin
            if (!phase_q) begin
              dp_op = OP_SLL;
            end else begin
              dp_op = OP_TRSUB;
              dp_di = ~b_q;
              dp_ci = 1'b1;
            end
          end
          default: begin
            if (!phase_q) begin
              dp_op = OP_ADDU;
              dp_di = b_q;
            end else begin
              dp_op = OP_SRL;
            end
          end
        endcase
        if (phase_q) begin
          cnt_d = cnt_q + CW'(1);
          if (last_k) begin
            cnt_d   = '0;
            state_d = S_CAPT;
          end
        end
      end

      S_CAPT: begin
        busy = 1'b1;
        if (func_q == F_ILL) begin
          res_hi_d  = '0;
          res_lo_d  = '0;
          illegal_d = 1'b1;
        end else begin
          res_hi_d = dp_pm[2*W-1:W];
          res_lo_d = dp_pm[W-1:0];
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_humansized_muldiv_seq.sv
// Bench for humansized_muldiv_seq: behavioural datapath plus arithmetic reference model,
// directed vector table, hand-written corner sequences and randomized operations.
module tb_humansized_muldiv_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [1:0]     func = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, illegal;
  logic [W-1:0]   res_hi, res_lo;
  logic [4:0]     dp_op;
  logic [W-1:0]   dp_di;
  logic           dp_ci;
  logic [2*W-1:0] dp_pm;

  int checks = 0;
  int errors = 0;

  humansized_muldiv_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .res_hi(res_hi), .res_lo(res_lo),
    .dp_op(dp_op), .dp_di(dp_di), .dp_ci(dp_ci), .dp_pm(dp_pm)
  );

  always #5 clk = ~clk;

  // datapath model: rP/rM with a carry/sign extension bit, no reset
  logic [W-1:0] rp_q, rm_q, rp_n, rm_n;
  logic         c_q, c_n;
  logic [W:0]   s9;
  logic [W+1:0] t10;

  always_comb begin
    rp_n = rp_q; rm_n = rm_q; c_n = c_q; s9 = '0; t10 = '0;
    if (dp_op[0]) begin
      rp_n = '0; rm_n = dp_di; c_n = 1'b0;
    end else if (dp_op[2:1] == 2'b01) begin
      rp_n = {c_q, rp_q[W-1:1]}; rm_n = {rp_q[0], rm_q[W-1:1]}; c_n = 1'b0;
    end else if (dp_op[2:1] == 2'b10) begin
      rp_n = {c_q, rp_q[W-1:1]}; rm_n = {rp_q[0], rm_q[W-1:1]};
    end else if (dp_op[2:1] == 2'b11) begin
      c_n = rp_q[W-1]; rp_n = {rp_q[W-2:0], rm_q[W-1]}; rm_n = {rm_q[W-2:0], 1'b0};
    end else begin
      case (dp_op[4:3])
        2'b00: begin
          if (rm_q[0]) begin
            s9 = {1'b0, rp_q} + {1'b0, dp_di} + (W+1)'(dp_ci);
            {c_n, rp_n} = s9;
          end else c_n = 1'b0;
        end
        2'b01: begin
          if (rm_q[0]) begin
            s9 = {rp_q[W-1], rp_q} + {dp_di[W-1], dp_di} + (W+1)'(dp_ci);
            {c_n, rp_n} = s9;
          end else c_n = rp_q[W-1];
        end
        2'b10: begin
          t10 = {1'b0, c_q, rp_q} + {2'b11, dp_di} + (W+2)'(dp_ci);
          if (!t10[W+1]) begin
            rp_n = t10[W-1:0]; c_n = 1'b0; rm_n[0] = 1'b1;
          end else rm_n[0] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    rp_q <= rp_n;
    rm_q <= rm_n;
    c_q  <= c_n;
  end
  assign dp_pm = {rp_q, rm_q};

  // reference model from plain arithmetic: returns {illegal, hi, lo}
  function automatic logic [2*W:0] ref_model(input logic [1:0] f, input logic [W-1:0] av,
                                             input logic [W-1:0] bv);
    int sa, sb, p;
    logic [2*W-1:0] r;
    r = '0;
    case (f)
      2'b00: r = (2*W)'(av) * (2*W)'(bv);
      2'b01: begin
        sa = int'($signed(av)); sb = int'($signed(bv)); p = sa * sb; r = p[2*W-1:0];
      end
      2'b10: r = (bv == 0) ? {av, {W{1'b1}}} : {W'(av % bv), W'(av / bv)};
      default: return {1'b1, {(2*W){1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // issue one request from IDLE; returns at #1 into the done cycle (or on timeout)
  task automatic do_op(input logic [1:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output int lat, output int busy_cnt);
    @(posedge clk);
    @(negedge clk);
    func = f; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] f, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [2*W-1:0] exp_res,
                          input logic exp_ill);
    int lat, bc, exp_lat;
    exp_lat = exp_ill ? 2 : 2*W + 3;
    do_op(f, av, bv, lat, bc);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bc, exp_lat - 1);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_result"}, {res_hi, res_lo}, exp_res);
    check({name, "_illegal"}, illegal, exp_ill);
  endtask

  typedef struct {
    string          name;
    logic [1:0]     f;
    logic [W-1:0]   av;
    logic [W-1:0]   bv;
    logic [2*W-1:0] exp_res;
    logic           exp_ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bc;
    logic [2*W:0] m;
    logic [1:0] rf;
    logic [W-1:0] ra, rb;

    vecs[0] = '{"mulu_200x3",  2'b00, 8'd200, 8'd3,   16'h0258, 1'b0};
    vecs[1] = '{"muls_m3x5",   2'b01, 8'hFD,  8'h05,  16'hFFF1, 1'b0};
    vecs[2] = '{"muls_80x80",  2'b01, 8'h80,  8'h80,  16'h4000, 1'b0};
    vecs[3] = '{"muls_7Fx81",  2'b01, 8'h7F,  8'h81,  16'hC0FF, 1'b0};
    vecs[4] = '{"divu_200d7",  2'b10, 8'd200, 8'd7,   16'h041C, 1'b0};
    vecs[5] = '{"divu_by0",    2'b10, 8'h37,  8'h00,  16'h37FF, 1'b0};
    vecs[6] = '{"illegal",     2'b11, 8'h12,  8'h34,  16'h0000, 1'b1};
    vecs[7] = '{"mulu_FFxFF",  2'b00, 8'hFF,  8'hFF,  16'hFE01, 1'b0};

    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_illegal", illegal, 0);
    check("reset_res", {res_hi, res_lo}, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 8; i++)
      check_op(vecs[i].name, vecs[i].f, vecs[i].av, vecs[i].bv, vecs[i].exp_res, vecs[i].exp_ill);

    // done lasts one cycle
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    // stray starts: cycle 5 of a DIVU and during its DONE cycle are ignored
    @(negedge clk);
    func = 2'b10; a = 8'd200; b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      start = (lat == 5);
      if (lat == 5) begin func = 2'b00; a = 8'h11; b = 8'h22; end
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
    check("stray_latency", lat, 2*W + 3);
    check("stray_result", {res_hi, res_lo}, 16'h041C);
    func = 2'b00; a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    check("start_in_done_ignored_busy", busy, 0);
    check("start_in_done_ignored_done", done, 0);
    @(posedge clk); #1 start = 1'b0;
    check("start_after_done_accepted", busy, 1);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    check("after_done_latency", lat, 2*W + 3);
    check("after_done_result", {res_hi, res_lo}, 16'h0100);

    // asynchronous reset during ITER
    @(posedge clk);
    @(negedge clk);
    func = 2'b00; a = 8'h9A; b = 8'h77; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midop_rst_busy", busy, 0);
    check("midop_rst_done", done, 0);
    check("midop_rst_res", {res_hi, res_lo}, 0);
    @(negedge clk) rst = 1'b0;
    check_op("divu_100d9_after_rst", 2'b10, 8'd100, 8'd9, 16'h010B, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) rb = '0;
      m = ref_model(rf, ra, rb);
      check_op($sformatf("rand%0d_f%0d_%0h_%0h", i, rf, ra, rb), rf, ra, rb, m[2*W-1:0], m[2*W]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
